// File: rtl/exe_alu.sv
// exe_alu: execute-stage ALU. Logic, shift and HI/LO reads are combinational.
// MTHI/MTLO/MULT/MULTU write HI/LO in one cycle. DIV/DIVU run on an iterative
// restoring divider and hold the pipeline through stall_o while it works.
module exe_alu #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [15:0]      imm,
  input  logic [4:0]       sa,
  output logic [WIDTH-1:0] result_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // ALU operation codes (shared with the decoder)
  localparam logic [4:0] ALU_DONOTHING = 5'd0;
  localparam logic [4:0] ALU_AND       = 5'd1;
  localparam logic [4:0] ALU_OR        = 5'd2;
  localparam logic [4:0] ALU_XOR       = 5'd3;
  localparam logic [4:0] ALU_NOR       = 5'd4;
  localparam logic [4:0] ALU_ANDI      = 5'd5;
  localparam logic [4:0] ALU_ORI       = 5'd6;
  localparam logic [4:0] ALU_XORI      = 5'd7;
  localparam logic [4:0] ALU_LUI       = 5'd8;
  localparam logic [4:0] ALU_SLL       = 5'd9;
  localparam logic [4:0] ALU_SRL       = 5'd10;
  localparam logic [4:0] ALU_SRA       = 5'd11;
  localparam logic [4:0] ALU_SLLV      = 5'd12;
  localparam logic [4:0] ALU_SRLV      = 5'd13;
  localparam logic [4:0] ALU_SRAV      = 5'd14;
  localparam logic [4:0] ALU_MFHI      = 5'd15;
  localparam logic [4:0] ALU_MFLO      = 5'd16;
  localparam logic [4:0] ALU_MTHI      = 5'd17;
  localparam logic [4:0] ALU_MTLO      = 5'd18;
  localparam logic [4:0] ALU_MULT      = 5'd19;
  localparam logic [4:0] ALU_MULTU     = 5'd20;
  localparam logic [4:0] ALU_DIV       = 5'd21;
  localparam logic [4:0] ALU_DIVU      = 5'd22;

  // Divider FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = $clog2(DIV_CYCLES);

  // Two's-complement negate when en is set (abs value and sign fix-up)
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Divider datapath: r_dvd shifts the dividend out and the quotient in
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_sign_a;
  logic             r_neg_q;
  logic             r_dz;

  logic                    w_is_div;
  logic                    w_sdiv;
  logic                    w_start;
  logic                    w_stall;
  logic                    w_we;
  logic [WIDTH:0]          w_shift;
  logic [WIDTH:0]          w_diff;
  logic                    w_qbit;
  logic [WIDTH-1:0]        w_rem_nxt;
  logic [WIDTH-1:0]        w_quo_fin;
  logic [WIDTH-1:0]        w_rem_fin;
  logic signed [2*WIDTH-1:0] w_sa_ext;
  logic signed [2*WIDTH-1:0] w_sb_ext;
  logic signed [2*WIDTH-1:0] w_smul;
  logic [2*WIDTH-1:0]      w_umul;

  assign hi_o = r_hi;
  assign lo_o = r_lo;

  assign w_is_div = (alucontrol == ALU_DIV) | (alucontrol == ALU_DIVU);
  assign w_sdiv   = (alucontrol == ALU_DIV);
  assign w_start  = (r_state == S_IDLE) & valid_i & ~flush_i & w_is_div;
  assign w_we     = valid_i & ~flush_i & ~stall_o;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  // Divide by zero leaves rem = |a|, so the remainder fix-up restores a itself
  assign w_quo_fin = r_dz ? {WIDTH{1'b1}} : f_neg(r_dvd, r_neg_q);
  assign w_rem_fin = f_neg(r_rem, r_sign_a);

  assign w_sa_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_sb_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_smul   = w_sa_ext * w_sb_ext;
  assign w_umul   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Stall: issue cycle of a divide plus every BUSY cycle; reset forces it low
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_start;
      S_BUSY:  w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign stall_o = w_stall & ~rst;

  // Combinational result mux
  always_comb begin
    result_o = '0;
    case (alucontrol)
      ALU_DONOTHING: result_o = '0;
      ALU_AND:  result_o = a & b;
      ALU_OR:   result_o = a | b;
      ALU_XOR:  result_o = a ^ b;
      ALU_NOR:  result_o = ~(a | b);
      ALU_ANDI: result_o = a & {{(WIDTH-16){1'b0}}, imm};
      ALU_ORI:  result_o = a | {{(WIDTH-16){1'b0}}, imm};
      ALU_XORI: result_o = a ^ {{(WIDTH-16){1'b0}}, imm};
      ALU_LUI:  result_o = {imm, {(WIDTH-16){1'b0}}};
      ALU_SLL:  result_o = b << sa;
      ALU_SRL:  result_o = b >> sa;
      ALU_SRA:  result_o = $unsigned($signed(b) >>> sa);
      ALU_SLLV: result_o = b << a[4:0];
      ALU_SRLV: result_o = b >> a[4:0];
      ALU_SRAV: result_o = $unsigned($signed(b) >>> a[4:0]);
      ALU_MFHI: result_o = r_hi;
      ALU_MFLO: result_o = r_lo;
      default:  result_o = '0;
    endcase
  end

  // Divider control FSM and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BUSY;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (flush_i)
            r_state <= S_IDLE;
          else if (r_cnt == CNT_W'(DIV_CYCLES - 1))
            r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Divider datapath: latch magnitudes on issue, iterate while BUSY
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_dvd    <= f_neg(a, w_sdiv & a[WIDTH-1]);
      r_dvs    <= f_neg(b, w_sdiv & b[WIDTH-1]);
      r_rem    <= '0;
      r_sign_a <= w_sdiv & a[WIDTH-1];
      r_neg_q  <= w_sdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_dz     <= (b == '0);
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
    end
  end

  // HI/LO: divider result wins over a same-cycle single-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_DONE) && !flush_i) begin
      r_lo <= w_quo_fin;
      r_hi <= w_rem_fin;
    end else if (w_we) begin
      case (alucontrol)
        ALU_MTHI:  r_hi <= a;
        ALU_MTLO:  r_lo <= a;
        ALU_MULT:  {r_hi, r_lo} <= w_smul;
        ALU_MULTU: {r_hi, r_lo} <= w_umul;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_alu.sv
// Directed testbench for exe_alu with immediate-assertion checks.
module tb_exe_alu;

  localparam logic [4:0] ALU_DONOTHING = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_XOR  = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_ORI  = 5'd6;
  localparam logic [4:0] ALU_XORI = 5'd7;
  localparam logic [4:0] ALU_LUI  = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_SLLV = 5'd12;
  localparam logic [4:0] ALU_SRAV = 5'd14;
  localparam logic [4:0] ALU_MFHI = 5'd15;
  localparam logic [4:0] ALU_MFLO = 5'd16;
  localparam logic [4:0] ALU_MTHI = 5'd17;
  localparam logic [4:0] ALU_MTLO = 5'd18;
  localparam logic [4:0] ALU_MULT = 5'd19;
  localparam logic [4:0] ALU_MULTU = 5'd20;
  localparam logic [4:0] ALU_DIV  = 5'd21;
  localparam logic [4:0] ALU_DIVU = 5'd22;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic [4:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic [15:0] imm;
  logic [4:0]  sa;
  logic [31:0] result_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  int n;

  exe_alu #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
    .alucontrol(alucontrol), .a(a), .b(b), .imm(imm), .sa(sa),
    .result_o(result_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                    input logic [15:0] im, input logic [4:0] s);
    alucontrol = c; a = x; b = y; imm = im; sa = s;
    settle();
  endtask

  // Counts stall cycles starting from the current one; bounded at 40
  task automatic count_stall(output int cnt);
    cnt = 0;
    while (stall_o === 1'b1 && cnt < 40) begin
      cnt++;
      cyc();
      settle();
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    alucontrol = ALU_DONOTHING; a = '0; b = '0; imm = '0; sa = '0;
    cyc(); cyc();
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    rst = 1'b0;
    valid_i = 1'b1;

    // Combinational ops
    op(ALU_ORI,  32'h000000F0, 32'h0, 16'h0F0F, 5'd0); chk("ori",  result_o, 32'h00000FFF);
    op(ALU_LUI,  32'h0, 32'h0, 16'h1234, 5'd0);         chk("lui",  result_o, 32'h12340000);
    op(ALU_SRAV, 32'h4, 32'h80000000, 16'h0, 5'd0);     chk("srav", result_o, 32'hF8000000);
    op(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0); chk("and", result_o, 32'hF000F000);
    op(ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0); chk("or",  result_o, 32'hFFF0FFF0);
    op(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0); chk("xor", result_o, 32'h0FF00FF0);
    op(ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0); chk("nor", result_o, 32'h000F000F);
    op(ALU_XORI, 32'hFFFF0000, 32'h0, 16'hFFFF, 5'd0);  chk("xori", result_o, 32'hFFFFFFFF);
    op(ALU_SLL,  32'h0, 32'h00000003, 16'h0, 5'd4);     chk("sll",  result_o, 32'h00000030);
    op(ALU_SRL,  32'h0, 32'h80000000, 16'h0, 5'd31);    chk("srl",  result_o, 32'h00000001);
    op(ALU_SRA,  32'h0, 32'h80000000, 16'h0, 5'd31);    chk("sra",  result_o, 32'hFFFFFFFF);
    op(ALU_SLLV, 32'd31, 32'h00000001, 16'h0, 5'd0);    chk("sllv", result_o, 32'h80000000);
    op(ALU_DONOTHING, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 5'd3); chk("nop", result_o, 32'h0);
    chk("nop_hi", hi_o, 32'h0);

    // MULT / MULTU
    op(ALU_MULT, 32'hFFFFFFFE, 32'h3, 16'h0, 5'd0);
    chk("mult_stall", {31'b0, stall_o}, 32'h0);
    cyc();
    op(ALU_MFHI, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFFA);
    chk("mfhi_after_mult", result_o, 32'hFFFFFFFF);
    op(ALU_MULTU, 32'hFFFFFFFE, 32'h3, 16'h0, 5'd0);
    cyc();
    op(ALU_MFLO, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("multu_hi", hi_o, 32'h00000002);
    chk("multu_lo", lo_o, 32'hFFFFFFFA);
    chk("mflo_after_multu", result_o, 32'hFFFFFFFA);

    // DIV -7 / 2
    op(ALU_DIV, 32'hFFFFFFF9, 32'h2, 16'h0, 5'd0);
    count_stall(n);
    chk("div1_stall_cycles", n, 33);
    chk("div1_done_hi_old", hi_o, 32'h00000002);
    cyc();
    op(ALU_MFHI, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("div1_lo", lo_o, 32'hFFFFFFFD);
    chk("div1_hi", hi_o, 32'hFFFFFFFF);
    chk("div1_mfhi", result_o, 32'hFFFFFFFF);
    chk("div1_idle", {31'b0, stall_o}, 32'h0);

    // DIVU by zero, then back-to-back DIV 0x80000000 / -1
    op(ALU_DIVU, 32'h00001234, 32'h0, 16'h0, 5'd0);
    count_stall(n);
    chk("divz_stall_cycles", n, 33);
    cyc();
    op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 16'h0, 5'd0);
    chk("divz_lo", lo_o, 32'hFFFFFFFF);
    chk("divz_hi", hi_o, 32'h00001234);
    chk("b2b_accept", {31'b0, stall_o}, 32'h1);
    count_stall(n);
    chk("ovf_stall_cycles", n, 33);
    cyc();
    op(ALU_MFLO, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("ovf_lo", lo_o, 32'h80000000);
    chk("ovf_hi", hi_o, 32'h0);

    // Flush mid-divide
    op(ALU_MTHI, 32'h55, 32'h0, 16'h0, 5'd0);
    cyc();
    op(ALU_MTLO, 32'h55, 32'h0, 16'h0, 5'd0);
    cyc();
    op(ALU_DIV, 32'd100, 32'd7, 16'h0, 5'd0);
    chk("fl_issue_stall", {31'b0, stall_o}, 32'h1);
    repeat (10) cyc();
    flush_i = 1'b1;
    settle();
    chk("fl_stall_ungated", {31'b0, stall_o}, 32'h1);
    cyc();
    flush_i = 1'b0;
    valid_i = 1'b0;
    settle();
    chk("fl_stall_low", {31'b0, stall_o}, 32'h0);
    chk("fl_hi", hi_o, 32'h55);
    chk("fl_lo", lo_o, 32'h55);
    valid_i = 1'b1;
    op(ALU_DIV, 32'hFFFFFF9C, 32'd7, 16'h0, 5'd0);
    chk("fl_new_accept", {31'b0, stall_o}, 32'h1);
    count_stall(n);
    chk("fl_new_stall_cycles", n, 33);
    cyc();
    op(ALU_MFLO, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("neg100_lo", lo_o, 32'hFFFFFFF2);
    chk("neg100_hi", hi_o, 32'hFFFFFFFE);

    // Reset mid-divide
    op(ALU_DIVU, 32'd1000, 32'd3, 16'h0, 5'd0);
    repeat (20) cyc();
    rst = 1'b1;
    settle();
    chk("rstmid_stall", {31'b0, stall_o}, 32'h0);
    chk("rstmid_hi", hi_o, 32'h0);
    chk("rstmid_lo", lo_o, 32'h0);
    cyc();
    rst = 1'b0;
    valid_i = 1'b0;
    settle();
    chk("rstmid_idle", {31'b0, stall_o}, 32'h0);
    valid_i = 1'b1;
    op(ALU_DIVU, 32'd100, 32'd7, 16'h0, 5'd0);
    count_stall(n);
    chk("divu_stall_cycles", n, 33);
    cyc();
    op(ALU_MFHI, 32'h0, 32'h0, 16'h0, 5'd0);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);
    chk("divu_mfhi", result_o, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
